// File: rtl/axi_packet.sv
`default_nettype none
// ============================================================================
// Module      : axi_packet
// Description : AXI4 memory-mapped slave backed by a MEMORY_DEPTH x DATA_WIDTH
//               word memory. Independent read and write channels accept INCR
//               bursts. A burst that crosses a 4 KB boundary or runs past the
//               end of memory is answered with SLVERR on every read beat (data
//               forced to zero) or on the write response (data discarded).
// Ports       : ACLK, ARESETn (synchronous, active-high: 1 = reset)
//               AR*/R*  read address and read data channels
//               AW*/W*/B* write address, write data and write response channels
// Revision    : 1.0 - initial release
// ============================================================================
module axi_packet #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // read address channel
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    // write address channel
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response channel
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY
);

    localparam int         c_IDX_W  = $clog2(MEMORY_DEPTH);
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    // Error rule evaluated once at address acceptance and held for the burst.
    function automatic logic f_burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                         input logic [7:0]            len,
                                         input logic [2:0]            size);
        logic [31:0] beats;
        logic [31:0] bytes;
        logic [31:0] offset;
        logic [31:0] word;
        beats  = 32'(len) + 32'd1;
        bytes  = beats << size;
        offset = 32'(addr[11:0]);
        word   = 32'(addr >> 2);
        return ((offset + bytes) > 32'd4096) || ((word + beats) > 32'(MEMORY_DEPTH));
    endfunction

    // Word index of a byte address; only reached for bursts already proven in range.
    function automatic logic [c_IDX_W-1:0] f_word(input logic [ADDR_WIDTH-1:0] addr);
        return c_IDX_W'(addr >> 2);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    logic [0:0]            r_rd_state;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [ADDR_WIDTH-1:0] r_rd_addr;   // byte address of the next beat to fetch
    logic [ADDR_WIDTH-1:0] r_rd_step;
    logic [7:0]            r_rd_len;
    logic [7:0]            r_rd_cnt;
    logic                  r_rd_err;

    logic                  w_ar_err;
    logic [ADDR_WIDTH-1:0] w_ar_step;

    assign w_ar_err  = f_burst_err(ARADDR, ARLEN, ARSIZE);
    assign w_ar_step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << ARSIZE;

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            r_rd_state <= c_R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= c_OKAY;
            r_rd_addr  <= '0;
            r_rd_step  <= '0;
            r_rd_len   <= '0;
            r_rd_cnt   <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            case (r_rd_state)
                c_R_IDLE: begin
                    r_arready <= 1'b1;
                    if (r_arready && ARVALID) begin
                        // Beat 0 is presented straight from the acceptance edge.
                        r_arready  <= 1'b0;
                        r_rd_state <= c_R_DATA;
                        r_rd_len   <= ARLEN;
                        r_rd_cnt   <= '0;
                        r_rd_err   <= w_ar_err;
                        r_rd_step  <= w_ar_step;
                        r_rd_addr  <= ARADDR + w_ar_step;
                        r_rvalid   <= 1'b1;
                        r_rlast    <= (ARLEN == 8'd0);
                        r_rresp    <= w_ar_err ? c_SLVERR : c_OKAY;
                        r_rdata    <= w_ar_err ? '0 : r_mem[f_word(ARADDR)];
                    end
                end
                c_R_DATA: begin
                    if (RREADY) begin
                        if (r_rlast) begin
                            r_rd_state <= c_R_IDLE;
                            r_arready  <= 1'b1;
                            r_rvalid   <= 1'b0;
                            r_rlast    <= 1'b0;
                            r_rresp    <= c_OKAY;
                            r_rdata    <= '0;
                        end else begin
                            r_rd_cnt  <= r_rd_cnt + 8'd1;
                            r_rlast   <= ((r_rd_cnt + 8'd1) == r_rd_len);
                            r_rd_addr <= r_rd_addr + r_rd_step;
                            r_rdata   <= r_rd_err ? '0 : r_mem[f_word(r_rd_addr)];
                        end
                    end
                end
                default: r_rd_state <= c_R_IDLE;
            endcase
        end
    end

    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RLAST   = r_rlast;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

    // ------------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------------
    logic [1:0]            r_wr_state;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_wr_addr;   // byte address of the current beat
    logic [ADDR_WIDTH-1:0] r_wr_step;
    logic [7:0]            r_wr_len;
    logic [7:0]            r_wr_cnt;
    logic                  r_wr_err;

    logic                  w_aw_err;
    logic [ADDR_WIDTH-1:0] w_aw_step;
    logic                  w_wr_fire;
    logic                  w_mem_we;
    logic                  w_unused_wlast;

    assign w_aw_err  = f_burst_err(AWADDR, AWLEN, AWSIZE);
    assign w_aw_step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << AWSIZE;
    assign w_wr_fire = (r_wr_state == c_W_DATA) && r_wready && WVALID;
    // Gated by reset so a burst interrupted by reset cannot touch memory.
    assign w_mem_we  = w_wr_fire && !r_wr_err && !ARESETn;

    // Burst length comes from the beat counter alone; WLAST carries no meaning here.
    assign w_unused_wlast = WLAST;

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            r_wr_state <= c_W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_OKAY;
            r_wr_addr  <= '0;
            r_wr_step  <= '0;
            r_wr_len   <= '0;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            case (r_wr_state)
                c_W_IDLE: begin
                    r_awready <= 1'b1;
                    if (r_awready && AWVALID) begin
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wr_state <= c_W_DATA;
                        r_wr_addr  <= AWADDR;
                        r_wr_step  <= w_aw_step;
                        r_wr_len   <= AWLEN;
                        r_wr_cnt   <= '0;
                        r_wr_err   <= w_aw_err;
                    end
                end
                c_W_DATA: begin
                    if (w_wr_fire) begin
                        r_wr_addr <= r_wr_addr + r_wr_step;
                        if (r_wr_cnt == r_wr_len) begin
                            r_wready   <= 1'b0;
                            r_bvalid   <= 1'b1;
                            r_bresp    <= r_wr_err ? c_SLVERR : c_OKAY;
                            r_wr_state <= c_W_RESP;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 8'd1;
                        end
                    end
                end
                c_W_RESP: begin
                    if (BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_bresp    <= c_OKAY;
                        r_awready  <= 1'b1;
                        r_wr_state <= c_W_IDLE;
                    end
                end
                default: r_wr_state <= c_W_IDLE;
            endcase
        end
    end

    // Memory has no reset; a same-cycle read of this word sees the old value.
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            r_mem[f_word(r_wr_addr)] <= WDATA;
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_packet.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_packet
// Description : Directed self-checking bench for axi_packet: OKAY write/read
//               round trip, 4 KB crossing and end-of-memory SLVERR bursts,
//               RREADY back-pressure, BREADY back-pressure and reset mid-read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_packet;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic [15:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = 3'd2;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [15:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = 3'd2;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;

    int checks = 0;
    int errors = 0;

    axi_packet #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr_burst(input logic [15:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input logic [1:0] eresp, input int bdly);
        chk("awready_idle", 32'(AWREADY), 32'd1);
        AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("awready_busy", 32'(AWREADY), 32'd0);
        chk("wready_on", 32'(WREADY), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = base + 32'(i); WLAST = (i == int'(len)); WVALID = 1'b1;
            tick();
            if (i < int'(len)) chk("wready_mid", 32'(WREADY), 32'd1);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("wready_off", 32'(WREADY), 32'd0);
        chk("bvalid", 32'(BVALID), 32'd1);
        chk("bresp", 32'(BRESP), 32'(eresp));
        for (int i = 0; i < bdly; i++) begin
            tick();
            chk("bvalid_hold", 32'(BVALID), 32'd1);
            chk("bresp_hold", 32'(BRESP), 32'(eresp));
            chk("awready_wait", 32'(AWREADY), 32'd0);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("bvalid_clr", 32'(BVALID), 32'd0);
        chk("bresp_clr", 32'(BRESP), 32'd0);
        chk("awready_back", 32'(AWREADY), 32'd1);
    endtask

    task automatic rd_burst(input logic [15:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input bit err, input bit toggle);
        int beat;
        int cyc;
        chk("arready_idle", 32'(ARREADY), 32'd1);
        ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        chk("arready_busy", 32'(ARREADY), 32'd0);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 64) begin
            chk("rvalid", 32'(RVALID), 32'd1);
            chk("rdata", RDATA, err ? 32'd0 : base + 32'(beat));
            chk("rresp", 32'(RRESP), err ? 32'd2 : 32'd0);
            chk("rlast", 32'(RLAST), (beat == int'(len)) ? 32'd1 : 32'd0);
            chk("arready_low", 32'(ARREADY), 32'd0);
            RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
            tick();
            if (RREADY) beat++;
            cyc++;
        end
        RREADY = 1'b0;
        chk("rd_beats", 32'(beat), 32'(len) + 32'd1);
        chk("rvalid_end", 32'(RVALID), 32'd0);
        chk("rlast_end", 32'(RLAST), 32'd0);
        chk("arready_end", 32'(ARREADY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        chk("rst_bresp", 32'(BRESP), 32'd0);
        ARESETn = 1'b0;
        tick();
        chk("rel_arready", 32'(ARREADY), 32'd1);
        chk("rel_awready", 32'(AWREADY), 32'd1);

        // OKAY round trip at 0x0010
        wr_burst(16'h0010, 8'd3, 32'hA000_0000, 2'b00, 0);
        rd_burst(16'h0010, 8'd3, 32'hA000_0000, 1'b0, 1'b0);

        // 16 bytes from 0x0FF8 cross the 4 KB boundary
        rd_burst(16'h0FF8, 8'd3, 32'd0, 1'b1, 1'b0);

        // last word is legal on its own; two words from 0x0FFC run off the end
        wr_burst(16'h0FFC, 8'd0, 32'h0000_C0DE, 2'b00, 0);
        rd_burst(16'h0FFC, 8'd1, 32'd0, 1'b1, 1'b0);
        wr_burst(16'h0FFC, 8'd1, 32'hDEAD_0000, 2'b10, 0);
        rd_burst(16'h0FFC, 8'd0, 32'h0000_C0DE, 1'b0, 1'b0);

        // BREADY held low, then 8-beat read under RREADY back-pressure
        wr_burst(16'h0100, 8'd7, 32'hB000_0000, 2'b00, 5);
        rd_burst(16'h0100, 8'd7, 32'hB000_0000, 1'b0, 1'b1);

        // reset in the middle of a read burst
        chk("mid_arready", 32'(ARREADY), 32'd1);
        ARADDR = 16'h0100; ARLEN = 8'd7; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        tick();
        tick();
        RREADY = 1'b0;
        chk("mid_rdata", RDATA, 32'hB000_0002);
        ARESETn = 1'b1;
        tick();
        chk("mid_rst_rvalid", 32'(RVALID), 32'd0);
        chk("mid_rst_arready", 32'(ARREADY), 32'd0);
        chk("mid_rst_rlast", 32'(RLAST), 32'd0);
        chk("mid_rst_rdata", RDATA, 32'd0);
        tick();
        chk("mid_rst_arready2", 32'(ARREADY), 32'd0);
        ARESETn = 1'b0;
        tick();
        chk("mid_rel_arready", 32'(ARREADY), 32'd1);
        chk("mid_rel_rvalid", 32'(RVALID), 32'd0);

        // memory survives reset
        rd_burst(16'h0104, 8'd1, 32'hB000_0001, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_packet.md
# axi_packet

AXI4 memory-mapped slave with independent read and write channels, backed by an internal word memory of MEMORY_DEPTH × DATA_WIDTH. Accepts INCR bursts, answers each burst with OKAY or SLVERR, and flags bursts that cross a 4 KB boundary or run past the end of memory. It is the end-point slave behind the shared AXI interface used by the read/write benches.

## Interface
- DATA_WIDTH, 32, data bus width (bits); one memory word per beat
- ADDR_WIDTH, 16, byte address width
- MEMORY_DEPTH, 1024, number of DATA_WIDTH words in memory
- ACLK  in  1  sole clock; all logic on rising edge
- ARESETn  in  1  reset: one clock; reset is synchronous and active-high (ARESETn = 1 resets)
- ARADDR  in  ADDR_WIDTH  read start byte address; ARLEN in 8 beats−1; ARSIZE in 3 bytes/beat = 1<<ARSIZE
- ARVALID in 1 / ARREADY out 1  read address handshake
- RDATA out DATA_WIDTH; RRESP out 2 (00 OKAY, 10 SLVERR); RLAST out 1; RVALID out 1 / RREADY in 1
- AWADDR in ADDR_WIDTH; AWLEN in 8; AWSIZE in 3; AWVALID in 1 / AWREADY out 1
- WDATA in DATA_WIDTH; WLAST in 1; WVALID in 1 / WREADY out 1
- BRESP out 2; BVALID out 1 / BREADY in 1

## Operation
- Read FSM: R_IDLE → R_DATA. Write FSM: W_IDLE → W_DATA → W_RESP. Both independent, may run concurrently.
- Error check on address acceptance, beats = LEN+1, bytes = beats × (1<<SIZE):
  - boundary = (addr mod 4096) + bytes > 4096
  - out_of_range = (addr>>2) + beats > MEMORY_DEPTH
  - error = boundary | out_of_range; latched for the whole burst.
- Beat address: word index = addr>>2; addr += 1<<SIZE each beat (12-bit low part not wrapped; error check already excludes crossing). Sizes < 2 still transfer full words.
- Read, no error: beat i returns mem[word index of beat i], RRESP=00.
- Read, error: still exactly LEN+1 beats, RDATA=0, RRESP=10 every beat; no memory access.
- Write, no error: each accepted W beat stores WDATA to the current word; BRESP=00.
- Write, error: W beats accepted and discarded; BRESP=10.
- Burst termination counted by beat counter only; WLAST ignored for termination (mismatch not flagged).
- Memory contents not affected by reset; undefined until written.
- Same-cycle read and write of same word: read returns old data.

## Timing
- In reset: ARREADY, AWREADY, RVALID, RLAST, WREADY, BVALID = 0; RDATA=0; RRESP=BRESP=00; FSMs to idle.
- First cycle after reset release: ARREADY=1, AWREADY=1.
- AR handshake at edge N (ARVALID&ARREADY): ARREADY=0 from N+1; RVALID=1 with beat 0 (RDATA/RRESP registered) from N+1.
- Beat advances on RVALID&RREADY; next beat valid the following cycle (one beat per cycle with RREADY held high). RVALID, RDATA, RRESP, RLAST held stable while RREADY=0.
- RLAST=1 only on beat LEN. After last handshake: RVALID=0, RLAST=0, ARREADY=1 next cycle.
- AW handshake at edge N: AWREADY=0, WREADY=1 from N+1. Beat written on WVALID&WREADY.
- After beat LEN accepted: WREADY=0, BVALID=1 next cycle; BVALID/BRESP held until BREADY; then AWREADY=1 next cycle.
- RRESP/BRESP reset to 00 when channel idle.
- Reset mid-burst: burst aborted, outputs to reset values, no further memory writes.

## Test plan
- Write AWADDR=0x0010, AWLEN=3, AWSIZE=2, data A0..A3; then read same → BRESP=00; 4 beats A0..A3, RRESP=00, RLAST only on beat 3; ARREADY low from cycle after handshake until after last beat.
- Read ARADDR=0x0FF8, ARLEN=3, ARSIZE=2 (16 bytes crosses 4 KB) → 4 beats, RDATA=0, RRESP=10, RLAST on beat 3.
- Read ARADDR=0x0FFC, ARLEN=1, ARSIZE=2 (word 1023+2 > 1024) → 2 beats RRESP=10; write same range → BRESP=10, memory word 1023 unchanged.
- Read ARLEN=7 with RREADY toggled every other cycle → 8 beats, RDATA/RLAST stable while RREADY=0, no beat lost or repeated.
- Write burst with BREADY held low 5 cycles → BVALID held, AWREADY=0 until BREADY handshake, then AWREADY=1 next cycle.
- Assert ARESETn=1 mid read burst → RVALID=0, ARREADY=0 during reset, ARREADY=1 first cycle after release.
